// File: rtl/soe_pkg.sv
// Shared types for serial_op_engine: FSM states, ALU op codes, beat-counter width helper.
package soe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MASKOR = 3'd0,
    OP_XADD   = 3'd1,
    OP_ABSX   = 3'd2,
    OP_MINLO  = 3'd3,
    OP_MAXSH  = 3'd4,
    OP_SATAND = 3'd5,
    OP_AVGOR  = 3'd6,
    OP_ROTX   = 3'd7
  } op_t;

  function automatic int beat_cnt_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/soe_alu.sv
// Combinational N-bit ALU for serial_op_engine; zero latency, no flow control.
module soe_alu
  import soe_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  op_t          op,
  output logic [N-1:0] res
);

  logic         a_lt_b;
  logic [N-1:0] mn;
  logic [N-1:0] mx;
  logic [N:0]   sum;

  always_comb begin
    a_lt_b = (a < b);
    mn     = a_lt_b ? a : b;
    mx     = a_lt_b ? b : a;
    // One extra bit carries the overflow for both saturation and averaging
    sum    = {1'b0, a} + {1'b0, b};
    res    = '0;
    case (op)
      OP_MASKOR: res = (a & b) | c;
      OP_XADD:   res = (a ^ b) + c;
      OP_ABSX:   res = (mx - mn) ^ c;
      OP_MINLO:  res = {c[N-1:N/2], mn[N/2-1:0]};
      OP_MAXSH:  res = mx + {c[N-2:0], 1'b0};
      OP_SATAND: res = (sum[N] ? {N{1'b1}} : sum[N-1:0]) & c;
      OP_AVGOR:  res = sum[N:1] | c;
      OP_ROTX:   res = {a[N-2:0], a[N-1]} ^ b ^ c;
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/serial_op_engine.sv
// Loads A/B in W-bit beats, applies a streamed op sequence to acc, drains acc in W-bit beats; all phases valid/ready.
// Op result lands 1 cycle after handshake; abort wins over everything. SOE_CHECKSUM_EN appends an XOR checksum beat.
module serial_op_engine
  import soe_pkg::*;
#(
  parameter int N     = 64,
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic             op_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] op_count
);

  localparam int K  = N / W;
  localparam int BW = beat_cnt_w(K);

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     alu_res;
  logic [W-1:0]     drain_dat;
  logic             beat_end;

  soe_alu #(.N(N)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .c   (acc_q),
    .op  (op_t'(op_code)),
    .res (alu_res)
  );

  assign beat_end = (beat_q == BW'(K - 1));

  // Ready/valid drop in the abort cycle so no transfer is claimed
  assign in_ready  = (state_q == LOAD)  && !abort;
  assign op_ready  = (state_q == EXEC)  && !abort;
  assign out_valid = (state_q == DRAIN) && !abort;
  assign out_data  = out_valid ? drain_dat : '0;
  assign busy      = (state_q != IDLE);
  assign state_o   = state_q;
  assign op_count  = cnt_q;

`ifdef SOE_CHECKSUM_EN
  logic         cks_q, cks_d;
  logic [W-1:0] cks_val;

  always_comb begin
    cks_val = '0;
    for (int i = 0; i < K; i++) cks_val ^= acc_q[i*W +: W];
  end

  assign drain_dat = cks_q ? cks_val : acc_q[beat_q*W +: W];
  assign out_last  = out_valid && cks_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cks_q <= 1'b0;
    else      cks_q <= cks_d;
  end
`else
  assign drain_dat = acc_q[beat_q*W +: W];
  assign out_last  = out_valid && beat_end;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
`ifdef SOE_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    if (abort) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        acc_d   = '0;
        beat_d  = '0;
`ifdef SOE_CHECKSUM_EN
        cks_d   = 1'b0;
`endif
      end
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_d     = '0;
          b_d     = '0;
          acc_d   = '0;
          beat_d  = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
        LOAD: if (in_valid) begin
          a_d[beat_q*W +: W] = a_in;
          b_d[beat_q*W +: W] = b_in;
          beat_d = beat_q + 1'b1;
          if (beat_end) state_d = EXEC;
        end
        EXEC: if (op_valid) begin
          acc_d = alu_res;
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          if (op_last) state_d = DRAIN;
        end
        DRAIN: if (out_ready) begin
`ifdef SOE_CHECKSUM_EN
          if (cks_q) begin
            cks_d   = 1'b0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
            if (beat_end) cks_d = 1'b1;
          end
`else
          beat_d = beat_q + 1'b1;
          if (beat_end) state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_op_engine.sv
// Scoreboard bench for serial_op_engine at default parameters (N=64, W=4).
module tb_serial_op_engine;

  logic       clk, rst, start, abort;
  logic       in_valid, in_ready, op_valid, op_ready, op_last;
  logic       out_valid, out_ready, out_last, busy;
  logic [3:0] a_in, b_in, out_data;
  logic [2:0] op_code;
  logic [1:0] state_o;
  logic [7:0] op_count;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  serial_op_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_last(op_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .state_o(state_o), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected beat on every output handshake
  always @(negedge clk) begin
    beat_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got beat %0h want none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        repeat (2) tick();
      end
      in_valid = 1'b1;
      a_in = a[i*4 +: 4];
      b_in = b[i*4 +: 4];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [2:0] code, input bit last);
    op_valid = 1'b1;
    op_code  = code;
    op_last  = last;
    tick();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic expect_result(input logic [63:0] r);
    logic [3:0] x;
    beat_t b;
    x = '0;
    for (int i = 0; i < 16; i++) begin
      b.d = r[i*4 +: 4];
      x ^= b.d;
`ifdef SOE_CHECKSUM_EN
      b.l = 1'b0;
`else
      b.l = (i == 15);
`endif
      exp_q.push_back(b);
    end
`ifdef SOE_CHECKSUM_EN
    b.d = x;
    b.l = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state_o == 2'd0) break;
    end
    out_ready = 1'b0;
    chk("drain_idle", state_o, 2'd0);
    chk("drain_all_beats", exp_q.size(), 0);
  endtask

  // ops packs up to four op codes, first op in the low bits; the last one carries op_last
  task automatic run_job(input logic [63:0] a, input logic [63:0] b, input int nops,
                         input logic [11:0] ops, input logic [63:0] res,
                         input bit gaps, input bit stall);
    do_start();
    chk("load_state", state_o, 2'd1);
    chk("cnt_cleared", op_count, 8'd0);
    load(a, b, gaps);
    chk("exec_state", state_o, 2'd2);
    expect_result(res);
    for (int i = 0; i < nops; i++) send_op(ops[3*i +: 3], i == nops - 1);
    chk("drain_state", state_o, 2'd3);
    chk("op_count_job", op_count, nops);
    if (stall) begin
      repeat (3) begin
        @(negedge clk);
        chk("stall_data", out_data, res[3:0]);
        chk("stall_valid", out_valid, 1'b1);
        tick();
      end
    end
    drain();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; a_in = '0; b_in = '0;
    op_valid = 1'b0; op_code = '0; op_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_o, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_op_count", op_count, 8'd0);
    rst = 1'b1;
    tick();

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", state_o, 2'd0);

    // (a^b)+0 = 0x3A, then {0x3A[63:32], min[31:0]} = 0x0F
    run_job(64'h35, 64'h0F, 2, {3'd0, 3'd0, 3'd3, 3'd1}, 64'h0F, 1'b0, 1'b0);
    chk("op_count_hold", op_count, 8'd2);
    run_job(64'h35, 64'h0F, 2, {3'd0, 3'd0, 3'd3, 3'd1}, 64'h0F, 1'b0, 1'b1);
    // op0 = 0x2000.., op5 saturates on carry -> all-ones & c
    run_job(64'hF000_0000_0000_0000, 64'h2000_0000_0000_0000, 2, {3'd0, 3'd0, 3'd5, 3'd0},
            64'h2000_0000_0000_0000, 1'b1, 1'b0);
    // 0x26, 0x81, 0xA3, 0xC6
    run_job(64'h35, 64'h0F, 4, {3'd7, 3'd6, 3'd4, 3'd2}, 64'hC6, 1'b0, 1'b0);
    // 0xC000.., 0x3FFF..FC, 0x4000..02, 0x8000..03
    run_job(64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 4, {3'd4, 3'd2, 3'd7, 3'd6},
            64'h8000_0000_0000_0003, 1'b0, 1'b0);
    // 0xC000.., then upper half of c kept with low half of min
    run_job(64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 2, {3'd0, 3'd0, 3'd3, 3'd6},
            64'hC000_0000_0000_0001, 1'b0, 1'b0);

    // abort during EXEC after one op
    do_start();
    load(64'h35, 64'h0F, 1'b0);
    send_op(3'd1, 1'b0);
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", state_o, 2'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cnt_kept", op_count, 8'd1);
    repeat (5) tick();
    chk("abort_no_valid", out_valid, 1'b0);
    out_ready = 1'b0;
    run_job(64'h35, 64'h0F, 2, {3'd0, 3'd0, 3'd3, 3'd1}, 64'h0F, 1'b0, 1'b0);

    // async reset mid-load
    do_start();
    in_valid = 1'b1; a_in = 4'h9; b_in = 4'h6;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_state", state_o, 2'd0);
    chk("arst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 300 op0 ops: acc = 0x35 & 0x0F = 0x05, op_count saturates
    do_start();
    load(64'h35, 64'h0F, 1'b1);
    expect_result(64'h05);
    for (int i = 0; i < 300; i++) send_op(3'd0, i == 299);
    chk("sat_state", state_o, 2'd3);
    chk("sat_op_count", op_count, 8'd255);
    drain();
    chk("sat_cnt_hold", op_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_op_engine.md
Name: serial_op_engine

Overview:
- Parametrised successor to the team's nibble-serial FSM compute block.
- Loads two N-bit operands W bits per beat, then applies a host-supplied sequence of ALU ops to an N-bit accumulator, then streams the result out W bits per beat.
- Uses valid/ready handshakes on all three phases (load, op stream, result drain) instead of a fixed op graph; supports backpressure and abort.
- Sits between the tt_um pin wrapper and the host test harness.

Parameters:
- N, 64, operand/accumulator width in bits.
- W, 4, beat width in bits. N % W == 0; K = N/W must be a power of two, K >= 2.
- CNT_W, 8, width of the op_count saturating counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a job; sampled in IDLE only
- abort  in  1  synchronous abort to IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted (high in LOAD)
- a_in  in  W  operand A chunk
- b_in  in  W  operand B chunk
- op_valid  in  1  op word valid
- op_ready  out  1  op accepted (high in EXEC)
- op_code  in  3  ALU op select, 0..7
- op_last  in  1  final op of the job
- out_valid  out  1  result beat valid
- out_ready  in  1  result beat consumed
- out_data  out  W  result chunk
- out_last  out  1  final result beat
- busy  out  1  state != IDLE
- state_o  out  2  encoded state
- op_count  out  CNT_W  ops executed this job; saturates at all-ones

Behaviour:
- Reset: state IDLE; A, B, acc, beat_cnt and op_count cleared; all outputs 0.
- States: IDLE=0, LOAD=1, EXEC=2, DRAIN=3.
- IDLE:
  - On start: clear A, B, acc, beat_cnt and op_count; go to LOAD next cycle.
  - in_valid, op_valid and out_ready are ignored in IDLE.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes A[beat_cnt*W +: W] and B[beat_cnt*W +: W], LSB chunk first, then increments beat_cnt.
  - The K-th beat wraps beat_cnt to 0 and moves to EXEC.
  - Stalls (in_valid=0) hold all state.
- EXEC:
  - op_ready=1.
  - Each handshake sets acc <= f(op_code, A, B, acc) on that clock edge (1-cycle latency) and increments op_count (saturating).
  - If op_last is set on the handshake beat, move to DRAIN.
  - A single op carrying op_last is a legal job.
- ALU ops (c = acc; arithmetic mod 2^N unless stated):
  - 0: (a&b)|c
  - 1: (a^b)+c
  - 2: |a-b| ^ c
  - 3: {c[N-1:N/2], min(a,b)[N/2-1:0]}
  - 4: max(a,b) + (c<<1)
  - 5: sat(a+b) & c, where sat clamps to all-ones on carry out
  - 6: floor((a+b)/2) | c, computed without overflow
  - 7: rotl1(a) ^ b ^ c
- DRAIN:
  - out_valid=1; out_data = acc[beat_cnt*W +: W]; out_last=1 when beat_cnt == K-1.
  - Advance beat_cnt only on out_ready. out_data stays stable while out_valid=1 and out_ready=0.
  - After the last beat is accepted, go to IDLE.
- abort:
  - Has priority over every other event.
  - From any non-IDLE state: IDLE next cycle; handshake outputs low; accumulator contents discarded.
  - op_count retains its value until the next start.
- Async reset mid-job: immediate IDLE with all registers cleared.
- Simultaneous start and abort in IDLE: abort wins; state stays IDLE.
- Outside its phase, in_ready/op_ready/out_valid are 0.

Optional Feature:
- SOE_CHECKSUM_EN defined: DRAIN emits one extra beat after the K result beats, carrying the XOR of all K result chunks. out_last moves to that beat.
- SOE_CHECKSUM_EN undefined: exactly K beats; no checksum logic is instantiated.

Decomposition:
- Package soe_pkg holds:
  - state_t enum (IDLE, LOAD, EXEC, DRAIN)
  - op_t enum (OP_MASKOR .. OP_ROTX)
  - localparam function clog2-based beat-count width helper
- One sub-module, soe_alu:
  - Purely combinational, parametrised by N.
  - Inputs a, b, c and op; output res.
  - Instantiated once, not eight times.

Test Plan:
- N=8, W=4: load beats (a,b)=(5,F),(3,0), i.e. A=0x35, B=0x0F; op1 then op3+op_last. Required: acc 0x3A, then 0x3F; out beats F,3; out_last on the 2nd beat; op_count=2.
- Same job with out_ready held low for 3 cycles on beat 0: out_data stays F; beat order and count unchanged.
- A=0xF0, B=0x20: op0 then op5+op_last. Required: acc 0x20, then 0x20 (sat 0xFF & 0x20); out beats 0,2.
- Abort asserted during EXEC after 1 op: IDLE next cycle; out_valid never rises. A following start then runs a clean job with op_count reset to 0.
- Defaults N=64, W=4: 16 in_valid beats with gaps, 300 op0 ops. Required: op_count saturates at 255; 16 output beats; A/B chunk order verified LSB-first.
- SOE_CHECKSUM_EN defined, first scenario repeated: beats F,3,C; out_last only on C.
